decode_stage_pipe: RTL

Parametrised successor to the combinational decode stage. Decodes one RV32I instruction per cycle, reads a parametrised internal register file with write-through bypass, and generates the full sign-extended immediate. Results are held in a registered ID/EX pipeline register with valid/ready handshake, load-use hazard bubbling and branch flush. Sits between fetch and execute; branch compare moves to execute, so there are no BrEq/BrLT inputs.

---
 rtl/decode_stage_pipe_pkg.sv | 77 +++++++
 rtl/decode_stage_pipe_if.sv | 39 +++
 rtl/decode_stage_pipe_regfile.sv | 37 +++
 rtl/decode_stage_pipe.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pipe_pkg.sv
// Shared RV32I decode definitions: opcodes, selector enums, control bundle,
// immediate generation and ALU-op decode helpers.
package klp32_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] LSM_B  = 3'b000;
  localparam logic [2:0] LSM_H  = 3'b001;
  localparam logic [2:0] LSM_W  = 3'b010;
  localparam logic [2:0] LSM_BU = 3'b100;
  localparam logic [2:0] LSM_HU = 3'b101;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_COPY_B
  } alu_sel_e;

  // alu_src_1_sel: 0 = rs1, 1 = pc; alu_src_2_sel: 0 = rs2, 1 = immediate;
  // mem_rw: 0 = read, 1 = write.
  typedef struct packed {
    logic       reg_wr_en;
    logic       alu_src_1_sel;
    logic       alu_src_2_sel;
    logic       br_u;
    logic       mem_rw;
    logic       is_branch;
    logic       is_jump;
    logic [2:0] load_store_mode;
    imm_sel_e   imm_sel;
    alu_sel_e   alu_sel;
    wb_sel_e    wb_sel;
    logic       uses_rs1;
    logic       uses_rs2;
  } decode_ctrl_t;

  function automatic logic [31:0] gen_imm(input logic [31:0] inst, input imm_sel_e sel);
    logic [31:0] imm;
    unique case (sel)
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'b0};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = {{20{inst[31]}}, inst[31:20]};
    endcase
    return imm;
  endfunction

  // funct7[5] selects SUB only for register-register ops, SRA for both forms.
  function automatic alu_sel_e alu_decode(input logic [2:0] f3, input logic f7b5,
                                          input logic is_op);
    alu_sel_e sel;
    unique case (f3)
      3'd0: if (is_op && f7b5) sel = ALU_SUB; else sel = ALU_ADD;
      3'd1: sel = ALU_SLL;
      3'd2: sel = ALU_SLT;
      3'd3: sel = ALU_SLTU;
      3'd4: sel = ALU_XOR;
      3'd5: if (f7b5) sel = ALU_SRA; else sel = ALU_SRL;
      3'd6: sel = ALU_OR;
      default: sel = ALU_AND;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/decode_stage_pipe_if.sv
// Fetch-to-decode and ID/EX handshake bundle.
interface decode_stage_pipe_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  import klp32_pkg::*;
  localparam int AW = $clog2(NREGS);

  logic            i_valid;
  logic            o_ready;
  logic [31:0]     i_inst;
  logic [XLEN-1:0] i_pc;
  logic [XLEN-1:0] i_pc_inc;
  logic            i_ex_ready;
  logic            o_valid;
  logic [31:0]     o_inst;
  logic [XLEN-1:0] o_pc;
  logic [XLEN-1:0] o_pc_inc;
  logic [XLEN-1:0] o_data_1;
  logic [XLEN-1:0] o_data_2;
  logic [XLEN-1:0] o_immediate;
  logic [AW-1:0]   o_rs1;
  logic [AW-1:0]   o_rs2;
  logic [AW-1:0]   o_rd;
  decode_ctrl_t    o_ctrl;
  logic            o_illegal;

  modport master (
    output i_valid, i_inst, i_pc, i_pc_inc, i_ex_ready,
    input  o_ready, o_valid, o_inst, o_pc, o_pc_inc, o_data_1, o_data_2,
           o_immediate, o_rs1, o_rs2, o_rd, o_ctrl, o_illegal
  );

  modport slave (
    input  i_valid, i_inst, i_pc, i_pc_inc, i_ex_ready,
    output o_ready, o_valid, o_inst, o_pc, o_pc_inc, o_data_1, o_data_2,
           o_immediate, o_rs1, o_rs2, o_rd, o_ctrl, o_illegal
  );
endinterface

// File: rtl/decode_stage_pipe_regfile.sv
// Parametrised register file: two async read ports, one sync write port,
// x0 hardwired to zero, optional same-cycle write-through bypass.
module regfile_param #(
  parameter int NREGS  = 32,
  parameter int XLEN   = 32,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(NREGS)-1:0] i_wr_addr,
  input  logic [XLEN-1:0]          i_wr_data,
  input  logic [$clog2(NREGS)-1:0] i_rd_addr_1,
  input  logic [$clog2(NREGS)-1:0] i_rd_addr_2,
  output logic [XLEN-1:0]          o_rd_data_1,
  output logic [XLEN-1:0]          o_rd_data_2
);
  logic [XLEN-1:0] mem [NREGS];

  // Write port; x0 is never stored, so its slot is never read either.
  always_ff @(posedge clk) begin
    if (i_wr_en && i_wr_addr != '0) mem[i_wr_addr] <= i_wr_data;
  end

  // Read ports with x0 forced to zero and optional writeback forwarding.
  always_comb begin
    o_rd_data_1 = '0;
    o_rd_data_2 = '0;
    if (i_rd_addr_1 != '0) begin
      if (BYPASS != 0 && i_wr_en && i_rd_addr_1 == i_wr_addr) o_rd_data_1 = i_wr_data;
      else o_rd_data_1 = mem[i_rd_addr_1];
    end
    if (i_rd_addr_2 != '0) begin
      if (BYPASS != 0 && i_wr_en && i_rd_addr_2 == i_wr_addr) o_rd_data_2 = i_wr_data;
      else o_rd_data_2 = mem[i_rd_addr_2];
    end
  end
endmodule

// File: rtl/decode_stage_pipe.sv
// RV32I decode stage with registered ID/EX output, load-use bubbling,
// back-pressure hold and branch flush.
module decode_stage_pipe
  import klp32_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  decode_stage_pipe_if.slave       bus,
  input  logic                     i_flush,
  input  logic                     i_reg_wr_en,
  input  logic [$clog2(NREGS)-1:0] i_write_addr,
  input  logic [XLEN-1:0]          i_writeback
);
  localparam int AW = $clog2(NREGS);

  if (XLEN != 32) begin : g_xlen_check
    $error("decode_stage_pipe supports XLEN=32 only");
  end

  typedef enum logic [1:0] {RUN, BUBBLE, HOLD} state_e;
  state_e state_q, state_d;

  logic [6:0]      opcode;
  logic [4:0]      rs1_idx, rs2_idx, rd_idx;
  decode_ctrl_t    ctrl_dec;
  logic            opc_ok, illegal, hazard, accept;
  logic [XLEN-1:0] rd_data_1, rd_data_2;

  logic            valid_q, illegal_q;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] pc_q, pc_inc_q, data_1_q, data_2_q, imm_q;
  logic [AW-1:0]   rs1_q, rs2_q, rd_q;
  decode_ctrl_t    ctrl_q;

  assign opcode  = bus.i_inst[6:0];
  assign rs1_idx = bus.i_inst[19:15];
  assign rs2_idx = bus.i_inst[24:20];
  assign rd_idx  = bus.i_inst[11:7];

  // Control decode from opcode/funct fields.
  always_comb begin
    ctrl_dec = '0;
    opc_ok   = 1'b1;
    unique case (opcode)
      OPC_LUI: begin
        ctrl_dec.reg_wr_en = 1'b1; ctrl_dec.alu_src_2_sel = 1'b1;
        ctrl_dec.imm_sel = IMM_U;  ctrl_dec.alu_sel = ALU_COPY_B;
      end
      OPC_AUIPC: begin
        ctrl_dec.reg_wr_en = 1'b1; ctrl_dec.alu_src_1_sel = 1'b1;
        ctrl_dec.alu_src_2_sel = 1'b1; ctrl_dec.imm_sel = IMM_U;
      end
      OPC_JAL: begin
        ctrl_dec.reg_wr_en = 1'b1; ctrl_dec.is_jump = 1'b1; ctrl_dec.alu_src_1_sel = 1'b1;
        ctrl_dec.alu_src_2_sel = 1'b1; ctrl_dec.imm_sel = IMM_J; ctrl_dec.wb_sel = WB_PC4;
      end
      OPC_JALR: begin
        ctrl_dec.reg_wr_en = 1'b1; ctrl_dec.is_jump = 1'b1; ctrl_dec.alu_src_2_sel = 1'b1;
        ctrl_dec.wb_sel = WB_PC4;  ctrl_dec.uses_rs1 = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl_dec.is_branch = 1'b1; ctrl_dec.br_u = bus.i_inst[13];
        ctrl_dec.alu_src_1_sel = 1'b1; ctrl_dec.alu_src_2_sel = 1'b1;
        ctrl_dec.imm_sel = IMM_B; ctrl_dec.uses_rs1 = 1'b1; ctrl_dec.uses_rs2 = 1'b1;
      end
      OPC_LOAD: begin
        ctrl_dec.reg_wr_en = 1'b1; ctrl_dec.alu_src_2_sel = 1'b1; ctrl_dec.wb_sel = WB_MEM;
        ctrl_dec.load_store_mode = bus.i_inst[14:12]; ctrl_dec.uses_rs1 = 1'b1;
      end
      OPC_STORE: begin
        ctrl_dec.mem_rw = 1'b1; ctrl_dec.alu_src_2_sel = 1'b1; ctrl_dec.imm_sel = IMM_S;
        ctrl_dec.load_store_mode = bus.i_inst[14:12];
        ctrl_dec.uses_rs1 = 1'b1; ctrl_dec.uses_rs2 = 1'b1;
      end
      OPC_OP_IMM: begin
        ctrl_dec.reg_wr_en = 1'b1; ctrl_dec.alu_src_2_sel = 1'b1; ctrl_dec.uses_rs1 = 1'b1;
        ctrl_dec.alu_sel = alu_decode(bus.i_inst[14:12], bus.i_inst[30], 1'b0);
      end
      OPC_OP: begin
        ctrl_dec.reg_wr_en = 1'b1; ctrl_dec.uses_rs1 = 1'b1; ctrl_dec.uses_rs2 = 1'b1;
        ctrl_dec.alu_sel = alu_decode(bus.i_inst[14:12], bus.i_inst[30], 1'b1);
      end
      OPC_MISC_MEM, OPC_SYSTEM: ;
      default: opc_ok = 1'b0;
    endcase
  end

  assign illegal = !opc_ok
                || (ctrl_dec.uses_rs1  && int'(rs1_idx) >= NREGS)
                || (ctrl_dec.uses_rs2  && int'(rs2_idx) >= NREGS)
                || (ctrl_dec.reg_wr_en && int'(rd_idx)  >= NREGS);

  assign hazard = bus.o_valid && bus.i_valid && !illegal
               && ctrl_q.wb_sel == WB_MEM && rd_q != '0
               && ((ctrl_dec.uses_rs1 && rs1_idx[AW-1:0] == rd_q)
                || (ctrl_dec.uses_rs2 && rs2_idx[AW-1:0] == rd_q));

  assign bus.o_ready = bus.i_ex_ready && !hazard && !i_flush;
  assign accept      = bus.i_valid && bus.o_ready;

  regfile_param #(.NREGS(NREGS), .XLEN(XLEN), .BYPASS(BYPASS)) u_regfile (
    .clk         (clk),
    .i_wr_en     (i_reg_wr_en),
    .i_wr_addr   (i_write_addr),
    .i_wr_data   (i_writeback),
    .i_rd_addr_1 (rs1_idx[AW-1:0]),
    .i_rd_addr_2 (rs2_idx[AW-1:0]),
    .o_rd_data_1 (rd_data_1),
    .o_rd_data_2 (rd_data_2)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Next-state: flush always returns to RUN, back-pressure holds, hazard bubbles.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (!bus.i_ex_ready) state_d = HOLD; else if (hazard) state_d = BUBBLE;
      BUBBLE:  if (!bus.i_ex_ready) state_d = HOLD; else state_d = RUN;
      HOLD:    if (bus.i_ex_ready) state_d = hazard ? BUBBLE : RUN;
      default: state_d = RUN;
    endcase
    if (i_flush) state_d = RUN;
  end

  // ID/EX register: reset > flush > hold > accept > bubble.
  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      valid_q <= 1'b0; illegal_q <= 1'b0; inst_q <= '0; pc_q <= '0; pc_inc_q <= '0;
      data_1_q <= '0; data_2_q <= '0; imm_q <= '0;
      rs1_q <= '0; rs2_q <= '0; rd_q <= '0; ctrl_q <= '0;
    end else if (!bus.i_ex_ready) begin
      valid_q <= valid_q;
    end else if (accept) begin
      valid_q   <= 1'b1;
      illegal_q <= illegal;
      inst_q    <= bus.i_inst;
      pc_q      <= bus.i_pc;
      pc_inc_q  <= bus.i_pc_inc;
      data_1_q  <= rd_data_1;
      data_2_q  <= rd_data_2;
      imm_q     <= gen_imm(bus.i_inst, ctrl_dec.imm_sel);
      rs1_q     <= rs1_idx[AW-1:0];
      rs2_q     <= rs2_idx[AW-1:0];
      rd_q      <= rd_idx[AW-1:0];
      ctrl_q    <= illegal ? '0 : ctrl_dec;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign bus.o_valid     = valid_q;
  assign bus.o_illegal   = illegal_q;
  assign bus.o_inst      = inst_q;
  assign bus.o_pc        = pc_q;
  assign bus.o_pc_inc    = pc_inc_q;
  assign bus.o_data_1    = data_1_q;
  assign bus.o_data_2    = data_2_q;
  assign bus.o_immediate = imm_q;
  assign bus.o_rs1       = rs1_q;
  assign bus.o_rs2       = rs2_q;
  assign bus.o_rd        = rd_q;
  assign bus.o_ctrl      = ctrl_q;
endmodule
